// File: rtl/pwm_multi_gen_if.sv
// pwm_multi_gen_if: control inputs and PWM outputs of the multi-channel PWM generator
interface pwm_multi_gen_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 16
);
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  logic                ena;
  logic [PRESC_W-1:0]  presc_i;
  logic [WIDTH-1:0]    period_i;
  logic                mode_i;
  logic [CHANNELS-1:0] pol_i;
  logic                duty_wr_i;
  logic [CH_W-1:0]     duty_ch_i;
  logic [WIDTH-1:0]    duty_i;
  logic [CHANNELS-1:0] pwm_o;
  logic                cycle_o;
  modport master (output ena, presc_i, period_i, mode_i, pol_i, duty_wr_i, duty_ch_i, duty_i,
                  input pwm_o, cycle_o);
  modport slave (input ena, presc_i, period_i, mode_i, pol_i, duty_wr_i, duty_ch_i, duty_i,
                 output pwm_o, cycle_o);
endinterface

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: shared prescaler/timebase with per-channel double-buffered duty comparators
module pwm_multi_gen #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 16
) (
  input logic             clk,
  input logic             rst_n,
  pwm_multi_gen_if.slave  bus
);
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d, cnt_nxt;
  logic [WIDTH-1:0]    per_s_q, per_s_d, per_a_q, per_a_d;
  logic                down_q, down_d, mode_s_q, mode_s_d, mode_a_q, mode_a_d;
  logic [WIDTH-1:0]    duty_s_q [CHANNELS];
  logic [WIDTH-1:0]    duty_s_d [CHANNELS];
  logic [WIDTH-1:0]    duty_a_q [CHANNELS];
  logic [WIDTH-1:0]    duty_a_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                cycle_q, cycle_d, tick, bnd;

  always_comb begin
    tick     = bus.ena && presc_q == bus.presc_i;
    presc_d  = !bus.ena ? presc_q : tick ? '0 : PRESC_W'(presc_q + 1);
    // centre mode climbs to P, then descends; reaching 0 again closes the period
    cnt_nxt  = !mode_a_q ? (cnt_q == per_a_q ? '0 : WIDTH'(cnt_q + 1))
             : (!down_q && cnt_q < per_a_q) ? WIDTH'(cnt_q + 1)
             : cnt_q == '0 ? '0 : WIDTH'(cnt_q - 1);
    bnd      = tick && cnt_nxt == '0;
    cnt_d    = tick ? cnt_nxt : cnt_q;
    down_d   = bnd ? 1'b0
             : (tick && mode_a_q && cnt_q >= per_a_q && cnt_q != '0) ? 1'b1 : down_q;
    per_s_d  = bus.period_i;
    mode_s_d = bus.mode_i;
    per_a_d  = bnd ? per_s_q : per_a_q;
    mode_a_d = bnd ? mode_s_q : mode_a_q;
    cycle_d  = bnd;
    duty_s_d = duty_s_q;
    duty_a_d = duty_a_q;
    pwm_d    = pwm_q;
    for (int i = 0; i < CHANNELS; i++) begin
      duty_s_d[i] = (bus.duty_wr_i && 32'(bus.duty_ch_i) == i) ? bus.duty_i : duty_s_q[i];
      duty_a_d[i] = bnd ? duty_s_q[i] : duty_a_q[i];
      pwm_d[i]    = bus.ena ? (cnt_q < duty_a_q[i]) ^ bus.pol_i[i] : pwm_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q  <= '0;
      cnt_q    <= '0;
      down_q   <= 1'b0;
      per_s_q  <= '1;
      per_a_q  <= '1;
      mode_s_q <= 1'b0;
      mode_a_q <= 1'b0;
      duty_s_q <= '{default: '0};
      duty_a_q <= '{default: '0};
      pwm_q    <= '0;
      cycle_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      down_q   <= down_d;
      per_s_q  <= per_s_d;
      per_a_q  <= per_a_d;
      mode_s_q <= mode_s_d;
      mode_a_q <= mode_a_d;
      duty_s_q <= duty_s_d;
      duty_a_q <= duty_a_d;
      pwm_q    <= pwm_d;
      cycle_q  <= cycle_d;
    end
  end

  assign bus.pwm_o   = pwm_q;
  assign bus.cycle_o = cycle_q;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen: directed checks of timing, double buffering, modes, prescaler, enable and reset
module tb_pwm_multi_gen;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          tests = 0;
  int          fails = 0;
  logic [63:0] pw, cy;
  int          n;
  logic        hi;

  pwm_multi_gen_if #(.WIDTH(8), .CHANNELS(4), .PRESC_W(16)) bus ();
  pwm_multi_gen #(.WIDTH(8), .CHANNELS(4), .PRESC_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.duty_wr_i = 1'b0;
  endtask

  // pw[k]/cy[k] hold the channel output and cycle_o seen after the k-th clock
  task automatic run(input int len, input int ch, input int wr_at, input logic [1:0] wch,
                     input logic [7:0] wd);
    pw = '0;
    cy = '0;
    for (int k = 0; k < len; k++) begin
      if (k == wr_at) begin
        bus.duty_wr_i = 1'b1;
        bus.duty_ch_i = wch;
        bus.duty_i    = wd;
      end
      step();
      pw[k] = bus.pwm_o[ch];
      cy[k] = bus.cycle_o;
    end
  endtask

  task automatic wait_cycle(input int budget);
    n  = 0;
    hi = 1'b0;
    do begin
      step();
      n++;
      hi = hi | (|bus.pwm_o);
    end while (!bus.cycle_o && n < budget);
  endtask

  initial begin
    bus.ena = 1'b0; bus.presc_i = '0; bus.period_i = 8'd9; bus.mode_i = 1'b0;
    bus.pol_i = 4'hF; bus.duty_wr_i = 1'b0; bus.duty_ch_i = '0; bus.duty_i = '0;
    step();
    step();
    check("rst_pwm", 64'(bus.pwm_o), 64'h0);
    check("rst_cycle", 64'(bus.cycle_o), 64'h0);
    rst_n = 1'b1;
    bus.pol_i = 4'h0;
    bus.duty_wr_i = 1'b1; bus.duty_ch_i = 2'd0; bus.duty_i = 8'd3;
    step();
    check("dis_write_pwm", 64'(bus.pwm_o), 64'h0);
    bus.ena = 1'b1;
    wait_cycle(300);
    check("first_period_len", 64'(n), 64'd256);
    check("first_period_low", 64'(hi), 64'h0);
    // edge mode, P=9, ch0 duty 3
    run(10, 0, -1, 2'd0, 8'd0);
    check("edge_pwm_a", pw, 64'h007);
    check("edge_cyc_a", cy, 64'h200);
    run(10, 0, -1, 2'd0, 8'd0);
    check("edge_pwm_b", pw, 64'h007);
    check("edge_cyc_b", cy, 64'h200);
    // double buffering
    run(10, 0, 4, 2'd0, 8'd7);
    check("dbuf_mid_cur", pw, 64'h007);
    run(10, 0, 9, 2'd0, 8'd5);
    check("dbuf_mid_next", pw, 64'h07F);
    run(10, 0, -1, 2'd0, 8'd0);
    check("dbuf_bnd_old", pw, 64'h07F);
    run(10, 0, -1, 2'd0, 8'd0);
    check("dbuf_bnd_new", pw, 64'h01F);
    // extremes and polarity on ch1
    run(10, 1, -1, 2'd0, 8'd0);
    check("duty0", pw, 64'h000);
    run(10, 1, 2, 2'd1, 8'd10);
    check("duty0_hold", pw, 64'h000);
    run(10, 1, -1, 2'd0, 8'd0);
    check("duty_gt_p", pw, 64'h3FF);
    bus.pol_i = 4'b0010;
    run(10, 1, 2, 2'd1, 8'd3);
    check("pol_full", pw, 64'h000);
    run(10, 1, -1, 2'd0, 8'd0);
    check("pol_duty3", pw, 64'h3F8);
    bus.pol_i = 4'h0;
    // centre mode, P=4, ch2 duty 2
    bus.period_i = 8'd4; bus.mode_i = 1'b1;
    run(10, 2, 0, 2'd2, 8'd2);
    check("ctr_switch_cyc", cy, 64'h200);
    run(8, 2, -1, 2'd0, 8'd0);
    check("ctr_pwm_a", pw, 64'h83);
    check("ctr_cyc_a", cy, 64'h80);
    run(8, 2, -1, 2'd0, 8'd0);
    check("ctr_pwm_b", pw, 64'h83);
    check("ctr_cyc_b", cy, 64'h80);
    // prescaler and enable
    bus.presc_i = 16'd2; bus.period_i = 8'd3; bus.mode_i = 1'b0;
    wait_cycle(100);
    check("presc_ctr_len", 64'(n), 64'd24);
    run(12, 2, -1, 2'd0, 8'd0);
    check("presc_pwm", pw, 64'h03F);
    check("presc_cyc", cy, 64'h800);
    run(4, 2, -1, 2'd0, 8'd0);
    check("ena_pre", pw, 64'hF);
    bus.ena = 1'b0;
    run(5, 2, -1, 2'd0, 8'd0);
    check("ena_frozen_pwm", pw, 64'h1F);
    check("ena_frozen_cyc", cy, 64'h0);
    bus.ena = 1'b1;
    run(8, 2, -1, 2'd0, 8'd0);
    check("ena_resume_pwm", pw, 64'h03);
    check("ena_resume_cyc", cy, 64'h80);
    // reset in the middle of a period
    bus.presc_i = '0; bus.period_i = 8'd9;
    run(4, 0, -1, 2'd0, 8'd0);
    check("rp_wrap_pwm", pw, 64'hF);
    check("rp_wrap_cyc", cy, 64'h8);
    run(5, 0, -1, 2'd0, 8'd0);
    check("rp_pre_pwm", pw, 64'h1F);
    bus.pol_i = 4'hF;
    rst_n = 1'b0;
    step();
    check("midrst_pwm", 64'(bus.pwm_o), 64'h0);
    check("midrst_cycle", 64'(bus.cycle_o), 64'h0);
    rst_n = 1'b1;
    bus.pol_i = 4'h0;
    bus.duty_wr_i = 1'b1; bus.duty_ch_i = 2'd0; bus.duty_i = 8'd3;
    wait_cycle(300);
    check("midrst_period_len", 64'(n), 64'd256);
    check("midrst_duty_zero", 64'(hi), 64'h0);
    run(10, 0, -1, 2'd0, 8'd0);
    check("reprog_pwm", pw, 64'h007);
    check("reprog_cyc", cy, 64'h200);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Multi-channel PWM generator: one shared prescaler and timebase counter, CHANNELS independent duty-cycle comparators.
- Programmable period and edge- or center-aligned mode.
- Duty, period and mode are double-buffered (shadow to active at period boundary), so updates never cause glitched or truncated pulses.
- Sits between the control/register interface and the output pads; replaces the single-channel fixed-divider PWM.

Parameters:
- WIDTH, 8, bit width of period, duty and timebase counter.
- CHANNELS, 4, number of PWM outputs (1..16).
- PRESC_W, 16, bit width of the prescaler compare value.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  count enable; 0 freezes prescaler, timebase and outputs.
- presc_i  input  PRESC_W  prescaler terminal value; tick every presc_i+1 clocks (not shadowed).
- period_i  input  WIDTH  timebase terminal value (shadowed).
- mode_i  input  1  0 = edge-aligned, 1 = center-aligned (shadowed).
- pol_i  input  CHANNELS  per-channel output inversion (not shadowed).
- duty_wr_i  input  1  one-clock write strobe for a duty shadow register.
- duty_ch_i  input  max(1,$clog2(CHANNELS))  channel index for the write.
- duty_i  input  WIDTH  duty value for the write.
- pwm_o  output  CHANNELS  registered PWM outputs.
- cycle_o  output  1  one-clock pulse at each period boundary.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Prescaler, timebase count and direction (up) cleared.
  - Duty shadow/active = 0; period shadow/active = all-ones; mode shadow/active = 0.
  - pwm_o = 0 and cycle_o = 0, independent of pol_i.
  - Reset mid-operation aborts the current period immediately.
- Prescaler: q counts 0..presc_i, wraps to 0; tick = ena && q==presc_i. presc_i=0 ticks every enabled clock.
- Edge mode:
  - On tick, cnt increments; at cnt==P (active period) next cnt=0.
  - Period length = P+1 ticks.
- Center mode:
  - cnt counts up 0..P, then down to 1, then returns to 0 going up.
  - Period length = 2P ticks. P=0: cnt stays 0, every tick is a boundary.
- Boundary = the tick on which next cnt is 0 at the start of a new period. On that edge:
  - active duty[all] <= shadow duty; active period <= shadow period; active mode <= shadow mode; direction <= up.
  - cycle_o = 1 for exactly that clock.
- Shadow writes:
  - duty_wr_i=1 writes duty_i into shadow[duty_ch_i] on that clock.
  - duty_ch_i >= CHANNELS is ignored.
  - period_i and mode_i are sampled into their shadows every clock.
  - Write coincident with boundary: active loads the pre-write shadow value; the new value applies at the following boundary.
  - Writes are accepted while ena=0.
- Compare:
  - pwm_o[i] <= (cnt < active_duty[i]) ^ pol_i[i], registered one clock after cnt changes.
  - duty=0 gives constant inactive level.
  - Edge mode: duty>P gives constant active level.
  - Center mode: duty>P gives constant active level; pulse is symmetric about cnt=0.
- ena=0: q, cnt, direction, pwm_o and active registers hold; cycle_o=0. On re-enable, counting resumes from the held state.
- Arithmetic: all compares unsigned, WIDTH bits; no overflow possible since cnt never exceeds P.

Test Plan:
- Edge basics (presc 0, period 9, mode 0, ch0 duty 3, pol 0) -> pwm_o[0] high 3 clocks of every 10; cycle_o pulses every 10 clocks, aligned one clock before the rising pwm_o edge.
- Double buffering: write ch0 duty 7 when cnt=4 -> current period still 3 high; next period 7 high. Write at boundary clock -> takes effect one period later.
- Extremes/polarity (period 9): duty 0 -> pwm_o[1] constant 0; duty 10 -> constant 1; pol_i[1]=1 with duty 3 -> low 3 / high 7 of every 10.
- Center mode (period 4, ch2 duty 2) -> cnt sequence 0,1,2,3,4,3,2,1 repeats; pwm_o[2] high 3 of 8 ticks, contiguous across the boundary (cnt 1,0,1); cycle_o every 8.
- Prescaler/enable (presc 2, period 3) -> cnt advances every 3 clocks, period = 12 clocks. ena low 5 clocks -> all outputs frozen, period stretched by exactly 5.
- Reset mid-period (rst_n low 1 clock at cnt=5) -> next clock pwm_o=0, cycle_o=0, duties 0, period 0xFF. Reprogram -> normal operation from cnt=0.
